// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: L2 line request to 4-beat memory burst adaptor; ADAPTOR_PERF_CNT_EN adds rd/wr line counters
module line_burst_adaptor #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_address,
    input  logic [s_line-1:0] line_wdata,
    output logic              line_resp,
    output logic [s_line-1:0] line_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [s_beat-1:0] mem_wdata,
    input  logic [s_beat-1:0] mem_rdata,
    input  logic              mem_resp
`ifdef ADAPTOR_PERF_CNT_EN
   ,output logic [31:0]       rd_line_count,
    output logic [31:0]       wr_line_count
`endif
);
    localparam int n_beats = s_line / s_beat;
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
    state_t            state, state_nx;
    logic [1:0]        k;
    logic [31:0]       addr_q;
    logic [s_line-1:0] wdata_q;
    logic              in_burst, last, start;
    assign in_burst = state == RD_BURST || state == WR_BURST;
    assign last     = mem_resp && k == 2'(n_beats - 1);
    assign start    = state == IDLE && (line_read || line_write);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state == IDLE ? (line_read ? RD_BURST : line_write ? WR_BURST : IDLE) :
                   in_burst      ? (last ? DONE : state) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_rdata <= '0;
        end else begin
            if (start) addr_q <= line_address;
            if (start && !line_read) wdata_q <= line_wdata;
            if (in_burst && mem_resp) k <= k + 2'd1;
            if (state == RD_BURST && mem_resp) line_rdata[int'(k)*s_beat +: s_beat] <= mem_rdata;
        end
    end
    assign mem_read    = state == RD_BURST;
    assign mem_write   = state == WR_BURST;
    assign line_resp   = state == DONE;
    assign mem_address = addr_q & ~((32'd1 << s_offset) - 32'd1);
    assign mem_wdata   = mem_write ? wdata_q[int'(k)*s_beat +: s_beat] : '0;
`ifdef ADAPTOR_PERF_CNT_EN
    // rd_q remembers the transaction type so DONE can bump the right counter
    logic rd_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q          <= 1'b0;
            rd_line_count <= '0;
            wr_line_count <= '0;
        end else begin
            if (start) rd_q <= line_read;
            if (state == DONE && rd_q) rd_line_count <= rd_line_count + 32'd1;
            if (state == DONE && !rd_q) wr_line_count <= wr_line_count + 32'd1;
        end
    end
`endif
endmodule

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL have parameters: s_offset, default 5, line offset bits; s_line, default 256, line width in bits; s_beat, default 64, burst beat width (s_line/s_beat = 4 beats).
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- line_read  in  1  line read request from L2 (arbiter-side cache)
- line_write  in  1  line write-back request from L2
- line_address  in  32  line request byte address
- line_wdata  in  s_line  write-back line
- line_resp  out  1  one-cycle completion pulse
- line_rdata  out  s_line  assembled read line, valid while line_resp=1
- mem_read  out  1  burst read to physical memory
- mem_write  out  1  burst write to physical memory
- mem_address  out  32  line-aligned burst address
- mem_wdata  out  s_beat  current write beat
- mem_rdata  in  s_beat  current read beat
- mem_resp  in  1  per-beat acknowledge

Function
REQ-003 SHALL implement FSM states IDLE, RD_BURST, WR_BURST, DONE.
REQ-004 SHALL, in IDLE with line_read=1, latch address and enter RD_BURST next cycle; line_write=1 (line_read=0) latches address and line_wdata and enters WR_BURST.
REQ-005 SHALL give line_read priority when line_read and line_write are both 1.
REQ-006 SHALL drive mem_address = latched address with low s_offset bits forced to 0, stable for the whole burst.
REQ-007 SHALL hold mem_read=1 throughout RD_BURST and mem_write=1 throughout WR_BURST, 0 in all other states.
REQ-008 SHALL keep a 2-bit beat counter k, 0 at burst start, incremented on each cycle with mem_resp=1.
REQ-009 SHALL, in RD_BURST with mem_resp=1, store mem_rdata into line_rdata bits [64k+63:64k].
REQ-010 SHALL, in WR_BURST, drive mem_wdata = latched line bits [64k+63:64k]; mem_resp=1 advances k.
REQ-011 SHALL leave the burst state for DONE on the cycle after mem_resp=1 with k=3; k wraps to 0.
REQ-012 SHALL assert line_resp=1 for exactly one cycle in DONE, then return to IDLE.
REQ-013 SHALL ignore line_read/line_write in DONE; a request still held on the IDLE cycle after DONE starts a new transaction.
REQ-014 SHALL ignore mem_resp in IDLE and DONE, and ignore changes on line_address/line_wdata after latching.
REQ-015 SHALL hold line_rdata at its last assembled value between transactions.
REQ-016 SHALL, with mem_resp permanently 1, complete a read in 6 cycles from request sample (1 latch + 4 beats + DONE).

Reset
REQ-017 SHALL, on rst_n=0, immediately force IDLE, k=0, line_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, line_rdata=0, including mid-burst; no partial line is reported after reset release.

Configuration
REQ-018 SHALL, when ADAPTOR_PERF_CNT_EN is defined, add outputs rd_line_count (32) and wr_line_count (32), reset to 0, each incremented on DONE of its transaction type, wrapping at 2^32.
REQ-019 SHALL, when ADAPTOR_PERF_CNT_EN is undefined, omit those ports and counters; all other behaviour identical.

Verification
REQ-020 Read 0x0000_1234, mem_rdata beats 0x11..11,0x22..22,0x33..33,0x44..44 with mem_resp=1 -> mem_address=0x0000_1220, line_rdata={0x44..44,0x33..33,0x22..22,0x11..11}, line_resp one cycle.
REQ-021 Write 0x8000_0040, line_wdata=256'hDDDD..CCCC..BBBB..AAAA.. -> mem_wdata beats AAAA,BBBB,CCCC,DDDD in order, mem_write high 4 resp-cycles, line_resp one cycle.
REQ-022 Read with mem_resp stalled 0 for 3 cycles between beats -> k holds, mem_read stays 1, correct line assembled.
REQ-023 line_read=line_write=1 at 0x40 -> read burst only, mem_write stays 0.
REQ-024 rst_n=0 after beat 2 of a read -> outputs 0 same cycle; next read returns only the new burst data.
REQ-025 ADAPTOR_PERF_CNT_EN defined, 3 reads + 2 writes -> rd_line_count=3, wr_line_count=2.
